// File: rtl/ac97_codec_responder_pkg.sv
// ---------------------------------------------------------------------------
// ac97_codec_responder_pkg
// Shared constants for the AC-link codec responder:
//   - bit positions of the tag and slot boundaries within a 256-bit frame
//   - AC'97 register addresses handled specially by the register file
//   - register reset defaults and fixed readback values
//   - small helpers for default lookup and write-permission decode
// ---------------------------------------------------------------------------
package ac97_codec_responder_pkg;

  // Frame bit positions (bit 0 is the first bit after the sync rise)
  localparam logic [7:0] B_TAG_LAST  = 8'd4;    // last tag bit that is used (slot4 valid)
  localparam logic [7:0] B_SLOT1_END = 8'd35;   // slot1 = bits 16..35
  localparam logic [7:0] B_SLOT2_END = 8'd55;   // slot2 = bits 36..55
  localparam logic [7:0] B_SLOT3_END = 8'd75;   // slot3 = bits 56..75
  localparam logic [7:0] B_SLOT4_END = 8'd95;   // slot4 = bits 76..95
  localparam logic [7:0] B_LAST      = 8'd255;

  // Tag bit indices inside the captured tag vector
  localparam int unsigned TAG_FRAME = 0;
  localparam int unsigned TAG_SLOT1 = 1;
  localparam int unsigned TAG_SLOT2 = 2;
  localparam int unsigned TAG_SLOT3 = 3;
  localparam int unsigned TAG_SLOT4 = 4;

  // Register addresses
  localparam logic [6:0] REG_RESET     = 7'h00;
  localparam logic [6:0] REG_MASTER    = 7'h02;
  localparam logic [6:0] REG_PCM       = 7'h18;
  localparam logic [6:0] REG_POWERDOWN = 7'h26;
  localparam logic [6:0] REG_VID1      = 7'h7C;
  localparam logic [6:0] REG_VID2      = 7'h7E;

  // Defaults and fixed readback values
  localparam logic [15:0] DEF_MASTER   = 16'h8000;
  localparam logic [15:0] DEF_PCM      = 16'h8808;
  localparam logic [15:0] POWERDOWN_RD = 16'h000F;

  // Frame alignment state
  typedef enum logic {
    FR_IDLE,
    FR_ACTIVE
  } frame_state_e;

  // Default value for a register file entry indexed by address[6:1]
  function automatic logic [15:0] reg_default(input logic [5:0] idx);
    if (idx == REG_MASTER[6:1]) return DEF_MASTER;
    if (idx == REG_PCM[6:1])    return DEF_PCM;
    return '0;
  endfunction

  // True for addresses whose storage may be overwritten (0x00 handled apart)
  function automatic logic is_writable(input logic [6:0] addr);
    return !addr[0] && (addr != REG_RESET) && (addr != REG_POWERDOWN) &&
           (addr != REG_VID1) && (addr != REG_VID2);
  endfunction

endpackage

// File: rtl/ac97_codec_responder_if.sv
// ---------------------------------------------------------------------------
// ac97_codec_responder_if
// Bundles the AC-link serial lines and the PCM / control side-band of the
// codec responder.
//   master : controller / bench side (drives sync, sdata_out, ADC samples)
//   slave  : codec side (drives sdata_in, DAC samples, status, volumes)
// ---------------------------------------------------------------------------
interface ac97_codec_responder_if;
  logic        ac97_sync;
  logic        ac97_sdata_out;
  logic        ac97_sdata_in;
  logic [19:0] adc_left;
  logic [19:0] adc_right;
  logic        adc_valid;
  logic [19:0] dac_left;
  logic [19:0] dac_right;
  logic        dac_strobe;
  logic        codec_ready;
  logic [15:0] master_vol;
  logic [15:0] pcm_vol;

  modport master (
    output ac97_sync, ac97_sdata_out, adc_left, adc_right, adc_valid,
    input  ac97_sdata_in, dac_left, dac_right, dac_strobe, codec_ready,
           master_vol, pcm_vol
  );

  modport slave (
    input  ac97_sync, ac97_sdata_out, adc_left, adc_right, adc_valid,
    output ac97_sdata_in, dac_left, dac_right, dac_strobe, codec_ready,
           master_vol, pcm_vol
  );
endinterface

// File: rtl/ac97_codec_responder_regs.sv
// ---------------------------------------------------------------------------
// ac97_codec_responder_regs
// 64 x 16 codec register file indexed by address[6:1].
//   i_clk, i_rst_n     : bit clock (posedge), async active-low reset
//   i_wr_en            : single-cycle write request
//   i_wr_addr/i_wr_data: write address / data; 0x00 restores all defaults,
//                        odd, 0x26, 0x7C, 0x7E are read-only
//   i_rd_addr          : combinational read address
//   o_rd_data          : readback value (fixed values for read-only regs)
//   o_master_vol       : register 0x02
//   o_pcm_vol          : register 0x18
// ---------------------------------------------------------------------------
module ac97_codec_responder_regs
  import ac97_codec_responder_pkg::*;
#(
  parameter logic [15:0] VENDOR_ID1 = 16'h4144,
  parameter logic [15:0] VENDOR_ID2 = 16'h5374
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wr_en,
  input  logic [6:0]  i_wr_addr,
  input  logic [15:0] i_wr_data,
  input  logic [6:0]  i_rd_addr,
  output logic [15:0] o_rd_data,
  output logic [15:0] o_master_vol,
  output logic [15:0] o_pcm_vol
);

  logic [15:0] r_mem [64];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < 64; i++) r_mem[i] <= reg_default(6'(i));
    end else if (i_wr_en) begin
      if (i_wr_addr == REG_RESET) begin
        for (int unsigned i = 0; i < 64; i++) r_mem[i] <= reg_default(6'(i));
      end else if (is_writable(i_wr_addr)) begin
        r_mem[i_wr_addr[6:1]] <= i_wr_data;
      end
    end
  end

  always_comb begin
    o_rd_data = '0;
    if (!i_rd_addr[0]) begin
      case (i_rd_addr)
        REG_POWERDOWN: o_rd_data = POWERDOWN_RD;
        REG_VID1:      o_rd_data = VENDOR_ID1;
        REG_VID2:      o_rd_data = VENDOR_ID2;
        default:       o_rd_data = r_mem[i_rd_addr[6:1]];
      endcase
    end
  end

  assign o_master_vol = r_mem[REG_MASTER[6:1]];
  assign o_pcm_vol    = r_mem[REG_PCM[6:1]];

endmodule

// File: rtl/ac97_codec_responder.sv
// ---------------------------------------------------------------------------
// ac97_codec_responder
// Codec-side end of the AC-link. Deframes SDATA_OUT (sampled on negedge),
// executes slot1/slot2 register commands, captures DAC PCM from slots 3/4
// and serializes SDATA_IN (driven on posedge) with tag, read response and
// ADC PCM.
//   ac97_bitclk  : bit clock, both edges used
//   ac97_reset_b : async active-low reset
//   bus (slave)  : sync/sdata lines, ADC inputs, DAC outputs, codec_ready,
//                  master_vol (0x02), pcm_vol (0x18)
// ---------------------------------------------------------------------------
module ac97_codec_responder
  import ac97_codec_responder_pkg::*;
#(
  parameter logic [15:0] VENDOR_ID1   = 16'h4144,
  parameter logic [15:0] VENDOR_ID2   = 16'h5374,
  parameter int unsigned READY_FRAMES = 2
) (
  input  logic                    ac97_bitclk,
  input  logic                    ac97_reset_b,
  ac97_codec_responder_if.slave   bus
);

  // Receive side (negedge domain)
  frame_state_e r_state;
  logic [7:0]   r_nbit;        // index of the bit sampled at the next negedge
  logic         r_sync_q;
  logic [18:0]  r_shift;
  logic [4:0]   r_tag;
  logic [7:0]   r_slot1;       // {R/W, addr[6:0]}
  logic [19:0]  r_slot3;
  logic         r_wr_en;
  logic [6:0]   r_wr_addr;
  logic [15:0]  r_wr_data;
  logic         r_pend_valid;
  logic [6:0]   r_pend_addr;
  logic [19:0]  r_dac_left;
  logic [19:0]  r_dac_right;
  logic         r_dac_upd;
  logic [7:0]   r_frames;
  logic         r_ready;

  // Transmit side (posedge domain)
  logic [95:0]  r_txf;
  logic         r_sdin;
  logic         r_resp_valid;
  logic         r_strobe;

  logic         w_sync_rise;
  logic         w_bit_ok;
  logic         w_complete;
  logic         w_cmd_gate;
  logic [19:0]  w_sample;
  logic [15:0]  w_rd_data;
  logic [6:0]   w_rsp_addr;
  logic [15:0]  w_rsp_data;
  logic [95:0]  w_frame;

  // A sync rise re-labels the current bit as 255, so no slot action fires on it
  assign w_sync_rise = bus.ac97_sync & ~r_sync_q;
  assign w_bit_ok    = (r_state == FR_ACTIVE) && !w_sync_rise;
  assign w_complete  = (r_state == FR_ACTIVE) && (r_nbit == B_LAST);
  assign w_cmd_gate  = r_tag[TAG_FRAME] && r_tag[TAG_SLOT1] && r_ready;
  assign w_sample    = {r_shift, bus.ac97_sdata_out};

  always_ff @(negedge ac97_bitclk or negedge ac97_reset_b) begin
    if (!ac97_reset_b) begin
      r_state      <= FR_IDLE;
      r_nbit       <= '0;
      r_sync_q     <= 1'b0;
      r_shift      <= '0;
      r_tag        <= '0;
      r_slot1      <= '0;
      r_slot3      <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_pend_valid <= 1'b0;
      r_pend_addr  <= '0;
      r_dac_left   <= '0;
      r_dac_right  <= '0;
      r_dac_upd    <= 1'b0;
      r_frames     <= '0;
      r_ready      <= 1'b0;
    end else begin
      r_sync_q  <= bus.ac97_sync;
      r_shift   <= w_sample[18:0];
      r_wr_en   <= 1'b0;
      r_dac_upd <= 1'b0;

      if (w_sync_rise) begin
        r_state <= FR_ACTIVE;
        r_nbit  <= '0;
      end else if (r_state == FR_ACTIVE) begin
        if (r_nbit == B_LAST) r_state <= FR_IDLE;
        r_nbit <= r_nbit + 8'd1;
      end

      if (w_complete && !r_ready) begin
        if (r_frames == 8'(READY_FRAMES - 1)) r_ready  <= 1'b1;
        else                                  r_frames <= r_frames + 8'd1;
      end

      if (w_bit_ok) begin
        // Tags shift in from the top so bit 0 ends up in r_tag[0]
        if (r_nbit <= B_TAG_LAST) r_tag <= {bus.ac97_sdata_out, r_tag[4:1]};

        case (r_nbit)
          B_SLOT1_END: r_slot1 <= w_sample[19:12];
          B_SLOT2_END: begin
            if (w_cmd_gate && r_slot1[7]) begin
              r_pend_valid <= 1'b1;
              r_pend_addr  <= r_slot1[6:0];
            end else if (r_resp_valid) begin
              r_pend_valid <= 1'b0;
            end
            if (w_cmd_gate && !r_slot1[7] && r_tag[TAG_SLOT2]) begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_slot1[6:0];
              r_wr_data <= w_sample[19:4];
            end
          end
          B_SLOT3_END: r_slot3 <= w_sample;
          B_SLOT4_END: begin
            if (r_tag[TAG_FRAME] && r_tag[TAG_SLOT3] && r_tag[TAG_SLOT4]) begin
              r_dac_left  <= r_slot3;
              r_dac_right <= w_sample;
              r_dac_upd   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  ac97_codec_responder_regs #(
    .VENDOR_ID1 (VENDOR_ID1),
    .VENDOR_ID2 (VENDOR_ID2)
  ) u_regs (
    .i_clk        (ac97_bitclk),
    .i_rst_n      (ac97_reset_b),
    .i_wr_en      (r_wr_en),
    .i_wr_addr    (r_wr_addr),
    .i_wr_data    (r_wr_data),
    .i_rd_addr    (r_pend_addr),
    .o_rd_data    (w_rd_data),
    .o_master_vol (bus.master_vol),
    .o_pcm_vol    (bus.pcm_vol)
  );

  assign w_rsp_addr = r_pend_valid ? r_pend_addr : '0;
  assign w_rsp_data = r_pend_valid ? w_rd_data   : '0;

  // Bits 0..95 of the outgoing frame, bit 0 in the MSB
  always_comb begin
    w_frame = {r_ready, r_pend_valid, r_pend_valid, bus.adc_valid, bus.adc_valid,
               11'b0, 1'b0, w_rsp_addr, 12'b0, w_rsp_data, 4'b0,
               bus.adc_left, bus.adc_right};
  end

  // The whole frame payload is snapshotted at b0, then shifted out one bit
  // per posedge; bits past 95 shift in as zeros.
  always_ff @(posedge ac97_bitclk or negedge ac97_reset_b) begin
    if (!ac97_reset_b) begin
      r_txf        <= '0;
      r_sdin       <= 1'b0;
      r_resp_valid <= 1'b0;
      r_strobe     <= 1'b0;
    end else begin
      r_strobe <= r_dac_upd;
      if (r_state == FR_ACTIVE && r_nbit == 8'd0) begin
        r_txf        <= {w_frame[94:0], 1'b0};
        r_sdin       <= w_frame[95];
        r_resp_valid <= r_pend_valid;
      end else if (r_state == FR_ACTIVE) begin
        r_txf  <= {r_txf[94:0], 1'b0};
        r_sdin <= r_txf[95];
      end else begin
        r_sdin <= 1'b0;
      end
    end
  end

  assign bus.ac97_sdata_in = r_sdin;
  assign bus.dac_left      = r_dac_left;
  assign bus.dac_right     = r_dac_right;
  assign bus.dac_strobe    = r_strobe;
  assign bus.codec_ready   = r_ready;

endmodule

// File: tb/tb_ac97_codec_responder.sv
module tb_ac97_codec_responder;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  logic [0:255] rx;
  logic [15:0]  mv55;
  logic [15:0]  mv56;
  int           strobe_cnt;
  int           strobe_pos;

  ac97_codec_responder_if bus_if ();

  ac97_codec_responder #(
    .VENDOR_ID1   (16'h4144),
    .VENDOR_ID2   (16'h5374),
    .READY_FRAMES (2)
  ) dut (
    .ac97_bitclk  (clk),
    .ac97_reset_b (rst_n),
    .bus          (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [0:255] mk_frame(input logic s1v, input logic s2v,
                                            input logic s3v, input logic s4v,
                                            input logic rw, input logic [6:0] a,
                                            input logic [15:0] d,
                                            input logic [19:0] l, input logic [19:0] r);
    logic [0:255] v;
    logic [19:0]  s1;
    logic [19:0]  s2;
    v  = '0;
    s1 = {rw, a, 12'h000};
    s2 = {d, 4'h0};
    v[0] = 1'b1;
    v[1] = s1v;
    v[2] = s2v;
    v[3] = s3v;
    v[4] = s4v;
    for (int i = 0; i < 20; i++) begin
      v[16 + i] = s1[19 - i];
      v[36 + i] = s2[19 - i];
      v[56 + i] = l[19 - i];
      v[76 + i] = r[19 - i];
    end
    return v;
  endfunction

  function automatic logic [19:0] slot_of(input logic [0:255] v, input int start);
    logic [19:0] s;
    for (int i = 0; i < 20; i++) s[19 - i] = v[start + i];
    return s;
  endfunction

  // Drives one frame bit per period (bit j), sync high on bits 0..14 and 255.
  // Stops after period 'cut'; with 'abort' set, sync rises on that period.
  task automatic run_frame(input logic [0:255] txv, input int cut, input logic abort);
    strobe_cnt = 0;
    strobe_pos = -1;
    for (int j = 0; j < 256; j++) begin
      @(posedge clk);
      #1;
      bus_if.ac97_sync      = (j < 15) || (j == 255) || (abort && j == cut);
      bus_if.ac97_sdata_out = (abort && j == cut) ? 1'b0 : txv[j];
      @(negedge clk);
      #1;
      rx[j] = bus_if.ac97_sdata_in;
      if (j == 55) mv55 = bus_if.master_vol;
      if (j == 56) mv56 = bus_if.master_vol;
      if (bus_if.dac_strobe) begin
        strobe_cnt++;
        if (strobe_pos < 0) strobe_pos = j;
      end
      if (j == cut) break;
    end
  endtask

  logic [0:255] idle_f;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus_if.ac97_sync      = 1'b0;
    bus_if.ac97_sdata_out = 1'b0;
    bus_if.adc_left       = 20'h13579;
    bus_if.adc_right      = 20'h2468A;
    bus_if.adc_valid      = 1'b1;
    idle_f = mk_frame(0, 0, 0, 0, 0, 7'h00, 16'h0000, 20'h0, 20'h0);

    repeat (3) @(negedge clk);
    #1;
    chk("rst_sdata_in",   32'(bus_if.ac97_sdata_in), 32'h0);
    chk("rst_dac_left",   32'(bus_if.dac_left),      32'h0);
    chk("rst_dac_strobe", 32'(bus_if.dac_strobe),    32'h0);
    chk("rst_ready",      32'(bus_if.codec_ready),   32'h0);
    chk("rst_master",     32'(bus_if.master_vol),    32'h8000);
    chk("rst_pcm",        32'(bus_if.pcm_vol),       32'h8808);
    rst_n = 1'b1;

    // Preamble period: first sync rise, next period is bit 0
    @(posedge clk);
    #1;
    bus_if.ac97_sync = 1'b1;

    // F1: idle frame
    run_frame(idle_f, 999, 1'b0);
    chk("f1_tag_ready", 32'(rx[0]), 32'h0);
    chk("f1_tag_resp",  32'(rx[1]), 32'h0);
    chk("f1_tag_adc",   32'(rx[3]), 32'h1);
    chk("f1_slot3",     32'(slot_of(rx, 56)), 32'h13579);
    chk("f1_slot4",     32'(slot_of(rx, 76)), 32'h2468A);

    // F2: write before ready is ignored, DAC capture still works
    run_frame(mk_frame(1, 1, 1, 1, 0, 7'h02, 16'h1234, 20'h0F0F0, 20'h5A5A5), 999, 1'b0);
    chk("f2_tag_ready",    32'(rx[0]), 32'h0);
    chk("f2_write_ignored", 32'(mv56), 32'h8000);
    chk("f2_dac_left",  32'(bus_if.dac_left),  32'h0F0F0);
    chk("f2_dac_right", 32'(bus_if.dac_right), 32'h5A5A5);

    // F3: ready from third frame
    run_frame(idle_f, 999, 1'b0);
    chk("f3_tag_ready", 32'(rx[0]), 32'h1);
    chk("f3_ready",     32'(bus_if.codec_ready), 32'h1);

    // F4: write 0x02 <- 0
    run_frame(mk_frame(1, 1, 0, 0, 0, 7'h02, 16'h0000, 20'h0, 20'h0), 999, 1'b0);
    chk("f4_mv_b55", 32'(mv55), 32'h8000);
    chk("f4_mv_b56", 32'(mv56), 32'h0000);

    // F5: read 0x02, F6 carries the response
    run_frame(mk_frame(1, 0, 0, 0, 1, 7'h02, 16'h0000, 20'h0, 20'h0), 999, 1'b0);
    run_frame(idle_f, 999, 1'b0);
    chk("f6_tag_b1", 32'(rx[1]), 32'h1);
    chk("f6_tag_b2", 32'(rx[2]), 32'h1);
    chk("f6_slot1",  32'(slot_of(rx, 16)), 32'h02000);
    chk("f6_slot2",  32'(slot_of(rx, 36)), 32'h00000);

    // F7..F13: vendor IDs, read-only writes, pending clear
    run_frame(mk_frame(1, 0, 0, 0, 1, 7'h7C, 16'h0000, 20'h0, 20'h0), 999, 1'b0);
    run_frame(mk_frame(1, 0, 0, 0, 1, 7'h7E, 16'h0000, 20'h0, 20'h0), 999, 1'b0);
    chk("f8_slot1_7c", 32'(slot_of(rx, 16)), 32'h7C000);
    chk("f8_slot2_7c", 32'(slot_of(rx, 36)), 32'h41440);
    run_frame(mk_frame(1, 1, 0, 0, 0, 7'h7C, 16'hFFFF, 20'h0, 20'h0), 999, 1'b0);
    chk("f9_slot2_7e", 32'(slot_of(rx, 36)), 32'h53740);
    run_frame(mk_frame(1, 0, 0, 0, 1, 7'h7C, 16'h0000, 20'h0, 20'h0), 999, 1'b0);
    chk("f10_resp_cleared", 32'(rx[1]), 32'h0);
    run_frame(mk_frame(1, 1, 0, 0, 0, 7'h26, 16'h0000, 20'h0, 20'h0), 999, 1'b0);
    chk("f11_7c_unchanged", 32'(slot_of(rx, 36)), 32'h41440);
    run_frame(mk_frame(1, 0, 0, 0, 1, 7'h26, 16'h0000, 20'h0, 20'h0), 999, 1'b0);
    run_frame(idle_f, 999, 1'b0);
    chk("f13_slot1_26", 32'(slot_of(rx, 16)), 32'h26000);
    chk("f13_slot2_26", 32'(slot_of(rx, 36)), 32'h000F0);

    // F14/F15: DAC strobe
    run_frame(mk_frame(0, 0, 1, 1, 0, 7'h00, 16'h0000, 20'h12345, 20'hABCDE), 999, 1'b0);
    chk("f14_dac_left",   32'(bus_if.dac_left),  32'h12345);
    chk("f14_dac_right",  32'(bus_if.dac_right), 32'hABCDE);
    chk("f14_strobe_cnt", 32'(strobe_cnt), 32'd1);
    chk("f14_strobe_pos", 32'(strobe_pos), 32'd96);
    run_frame(mk_frame(0, 0, 0, 1, 0, 7'h00, 16'h0000, 20'h11111, 20'h22222), 999, 1'b0);
    chk("f15_no_strobe", 32'(strobe_cnt), 32'd0);
    chk("f15_dac_hold",  32'(bus_if.dac_left), 32'h12345);

    // F16: sync rise at b40 mid-write, F17 decodes normally
    run_frame(mk_frame(1, 1, 0, 0, 0, 7'h02, 16'h5555, 20'h0, 20'h0), 40, 1'b1);
    run_frame(mk_frame(1, 1, 0, 0, 0, 7'h18, 16'h0000, 20'h0, 20'h0), 999, 1'b0);
    chk("f17_master_kept", 32'(bus_if.master_vol), 32'h0000);
    chk("f17_pcm_written", 32'(bus_if.pcm_vol),    32'h0000);
    chk("f17_tag_ready",   32'(rx[0]), 32'h1);

    // F18: write 0x00 restores defaults
    run_frame(mk_frame(1, 1, 0, 0, 0, 7'h00, 16'h0000, 20'h0, 20'h0), 999, 1'b0);
    chk("f18_pcm_default",    32'(bus_if.pcm_vol),     32'h8808);
    chk("f18_master_default", 32'(bus_if.master_vol),  32'h8000);
    chk("f18_ready_kept",     32'(bus_if.codec_ready), 32'h1);

    // F19: write 0x02, then async reset mid-frame at b59
    run_frame(mk_frame(1, 1, 0, 0, 0, 7'h02, 16'h1234, 20'h0, 20'h0), 59, 1'b0);
    chk("f19_master_pre", 32'(bus_if.master_vol),    32'h1234);
    chk("f19_sdin_pre",   32'(bus_if.ac97_sdata_in), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sdata_in", 32'(bus_if.ac97_sdata_in), 32'h0);
    chk("mid_rst_dac_left", 32'(bus_if.dac_left),      32'h0);
    chk("mid_rst_dac_right", 32'(bus_if.dac_right),    32'h0);
    chk("mid_rst_strobe",   32'(bus_if.dac_strobe),    32'h0);
    chk("mid_rst_ready",    32'(bus_if.codec_ready),   32'h0);
    chk("mid_rst_master",   32'(bus_if.master_vol),    32'h8000);
    chk("mid_rst_pcm",      32'(bus_if.pcm_vol),       32'h8808);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
